// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: sends a latched PAT_W-bit pattern MSB first, one bit per
// clock, repeated repeat_cnt times, with gap_len idle cycles between frames.
// All outputs except busy and present_state come straight from flops.
// Build option: define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity
// bit (XOR of the pattern bits) after the last pattern bit of every frame.
module serial_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic [2:0]       present_state
);

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_SHIFT = 3'b001;
  localparam logic [2:0] ST_GAP   = 3'b010;
  localparam logic [2:0] ST_DONE  = 3'b011;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int FRAME_W = PAT_W + 1;
`else
  localparam int FRAME_W = PAT_W;
`endif

  localparam int               BIT_W    = $clog2(FRAME_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  // Index of the final pattern bit; only reachable as a non-final slot when
  // the parity bit follows it.
  localparam logic [BIT_W-1:0] LAST_PAT = BIT_W'(PAT_W - 1);

  logic [2:0]       state_reg, state_next;
  logic [PAT_W-1:0] pat_reg, pat_next;
  logic [PAT_W-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0] rep_reg, rep_next;
  logic [GAP_W-1:0] gap_len_reg, gap_len_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             dout_reg, dout_next;
  logic             valid_reg, valid_next;
  logic             frame_reg, frame_next;
  logic             done_reg, done_next;
  logic             parity_bit;

  assign parity_bit = ^pat_reg;

  // Next-state and next-output logic; every non-SHIFT output defaults to 0.
  always_comb begin
    state_next   = state_reg;
    pat_next     = pat_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    rep_next     = rep_reg;
    gap_len_next = gap_len_reg;
    gap_cnt_next = gap_cnt_reg;
    dout_next    = 1'b0;
    valid_next   = 1'b0;
    frame_next   = 1'b0;
    done_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          pat_next     = pattern;
          rep_next     = repeat_cnt;
          gap_len_next = gap_len;
          if (repeat_cnt != '0) begin
            state_next   = ST_SHIFT;
            dout_next    = pattern[PAT_W-1];
            valid_next   = 1'b1;
            frame_next   = 1'b1;
            shift_next   = {pattern[PAT_W-2:0], 1'b0};
            bit_cnt_next = '0;
          end else begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (bit_cnt_reg != LAST_BIT) begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          valid_next   = 1'b1;
          dout_next    = (bit_cnt_reg == LAST_PAT) ? parity_bit : shift_reg[PAT_W-1];
          shift_next   = {shift_reg[PAT_W-2:0], 1'b0};
        end else begin
          // Last bit of a frame: one repetition consumed (saturating at 0).
          rep_next = (rep_reg != '0) ? rep_reg - 1'b1 : '0;
          if (rep_reg <= CNT_W'(1)) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else if (gap_len_reg != '0) begin
            state_next   = ST_GAP;
            gap_cnt_next = gap_len_reg;
          end else begin
            dout_next    = pat_reg[PAT_W-1];
            valid_next   = 1'b1;
            frame_next   = 1'b1;
            shift_next   = {pat_reg[PAT_W-2:0], 1'b0};
            bit_cnt_next = '0;
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (gap_cnt_reg <= GAP_W'(1)) begin
          state_next   = ST_SHIFT;
          gap_cnt_next = '0;
          dout_next    = pat_reg[PAT_W-1];
          valid_next   = 1'b1;
          frame_next   = 1'b1;
          shift_next   = {pat_reg[PAT_W-2:0], 1'b0};
          bit_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg - 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      pat_reg     <= '0;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      rep_reg     <= '0;
      gap_len_reg <= '0;
      gap_cnt_reg <= '0;
      dout_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      frame_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pat_reg     <= pat_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      rep_reg     <= rep_next;
      gap_len_reg <= gap_len_next;
      gap_cnt_reg <= gap_cnt_next;
      dout_reg    <= dout_next;
      valid_reg   <= valid_next;
      frame_reg   <= frame_next;
      done_reg    <= done_next;
    end
  end

  assign dout          = dout_reg;
  assign dout_valid    = valid_reg;
  assign frame_start   = frame_reg;
  assign done          = done_reg;
  assign present_state = state_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: table-driven bursts, hand-written abort/reset/start
// corner cases and random bursts, all compared cycle by cycle against a
// waveform built from the burst rules (frames, gaps, done cycle).
module tb_serial_pattern_tx;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int PAT_W   = 4;
  localparam int FRAME_W = PAT_W + PAR;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] pattern = '0;
  logic [7:0] repeat_cnt = '0;
  logic [3:0] gap_len = '0;
  logic       dout, dout_valid, frame_start, busy, done;
  logic [2:0] present_state;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle record: {state, busy, dout, valid, frame_start, done}
  logic [7:0] exp_q[$];

  serial_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .gap_len(gap_len),
    .dout(dout), .dout_valid(dout_valid), .frame_start(frame_start),
    .busy(busy), .done(done), .present_state(present_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rec(input logic [2:0] st, input logic b, input logic d,
                                     input logic v, input logic f, input logic dn);
    return {st, b, d, v, f, dn};
  endfunction

  function automatic logic [7:0] sample();
    return {present_state, busy, dout, dout_valid, frame_start, done};
  endfunction

  task automatic check8(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%b expected=%b (state,busy,dout,valid,frame,done)", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Expected waveform: R frames of FRAME_W bits, G idle cycles between frames,
  // one done cycle, then one idle cycle.
  task automatic build_expected(input logic [3:0] p, input int r, input int g);
    exp_q.delete();
    for (int rr = 0; rr < r; rr++) begin
      for (int b = 0; b < FRAME_W; b++) begin
        logic bv;
        bv = (b < PAT_W) ? p[PAT_W-1-b] : (($countones(p) % 2) == 1);
        exp_q.push_back(rec(3'b001, 1'b1, bv, 1'b1, (b == 0), 1'b0));
      end
      if (rr < r - 1)
        for (int k = 0; k < g; k++) exp_q.push_back(rec(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    exp_q.push_back(rec(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(rec(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Called at a negedge. Starts a burst, compares every cycle; abort_at>0
  // raises abort during that cycle; scramble pokes start/inputs while busy.
  task automatic run_burst(input string name, input logic [3:0] p, input int r, input int g,
                           input int abort_at, input bit scramble, output int done_at);
    logic [7:0] act;
    build_expected(p, r, g);
    if (abort_at > 0) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      for (int k = 0; k < 3; k++) exp_q.push_back(rec(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    pattern = p; repeat_cnt = 8'(r); gap_len = 4'(g);
    start = 1'b1; abort = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    done_at = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      act = sample();
      check8(name, i + 1, act, exp_q[i]);
      if (act[0] && done_at == 0) done_at = i + 1;
      start = 1'b0; abort = 1'b0;
      if (abort_at == i + 1) abort = 1'b1;
      if (scramble && ((abort_at == 0) ? (i < exp_q.size() - 1) : (i + 1 < abort_at))) begin
        start = 1'($urandom); pattern = 4'($urandom);
        repeat_cnt = 8'($urandom); gap_len = 4'($urandom);
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  typedef struct {
    logic [3:0] pat;
    int rep;
    int gap;
    int done_np;  // done cycle without parity bit
    int done_p;   // done cycle with parity bit
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d;
    vecs[0] = '{4'b1101, 1, 0,  5,  6};
    vecs[1] = '{4'b1101, 3, 2, 17, 20};
    vecs[2] = '{4'b0000, 0, 5,  1,  1};
    vecs[3] = '{4'b1010, 2, 0,  9, 11};
    vecs[4] = '{4'b0110, 2, 15, 24, 26};
    vecs[5] = '{4'b1111, 4, 1, 20, 24};

    repeat (3) @(negedge clk);
    check8("reset_hold", 0, sample(), 8'h00);
    reset = 1'b0;
    @(negedge clk);
    check8("after_reset", 0, sample(), 8'h00);

    // Table of directed bursts, back to back (start in first IDLE after DONE).
    for (int i = 0; i < 6; i++) begin
      run_burst($sformatf("table%0d", i), vecs[i].pat, vecs[i].rep, vecs[i].gap, 0, 1'b0, d);
      check_int($sformatf("table%0d_done_cycle", i), d, (PAR != 0) ? vecs[i].done_p : vecs[i].done_np);
    end

    // Abort during the 3rd bit of the 2nd frame, with a stray start mid-burst.
    run_burst("abort_mid", 4'b1101, 2, 3, FRAME_W + 3 + 3, 1'b1, d);
    check_int("abort_no_done", d, 0);

    // Abort together with start in IDLE: nothing starts.
    @(negedge clk);
    pattern = 4'b1011; repeat_cnt = 8'd3; gap_len = 4'd0; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check8("abort_start_idle", k + 1, sample(), 8'h00);
    end

    // Asynchronous reset in the middle of the gap, then a clean burst.
    build_expected(4'b1101, 2, 3);
    pattern = 4'b1101; repeat_cnt = 8'd2; gap_len = 4'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < FRAME_W + 2; i++) begin
      @(negedge clk);
      check8("pre_reset", i + 1, sample(), exp_q[i]);
    end
    #2 reset = 1'b1;
    #1 check8("async_reset", FRAME_W + 2, sample(), 8'h00);
    @(negedge clk);
    check8("reset_held", 0, sample(), 8'h00);
    reset = 1'b0;
    run_burst("post_reset", 4'b1001, 2, 1, 0, 1'b0, d);
    check_int("post_reset_done_cycle", d, 2 * FRAME_W + 1 + 1);

    // Maximum repeat count is sent in full.
    run_burst("max_repeat", 4'b0111, 255, 1, 0, 1'b0, d);
    check_int("max_repeat_done_cycle", d, 255 * FRAME_W + 254 + 1);

    // Random bursts with input scrambling while busy.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] rp;
      int rr, rg;
      rp = 4'($urandom);
      rr = $urandom_range(0, 5);
      rg = $urandom_range(0, 3);
      run_burst($sformatf("rand%0d", n), rp, rr, rg, 0, 1'b1, d);
      check_int($sformatf("rand%0d_done_cycle", n), d,
                (rr == 0) ? 1 : rr * FRAME_W + (rr - 1) * rg + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial pattern transmitter. Shifts a programmable PAT_W-bit pattern out on a 1-bit line, MSB first, one bit per clock, repeated a programmable number of times.
- Programmable idle gap between repetitions.
- Transmit-side counterpart of the team's Moore pattern-recognition FSMs. Its dout feeds a detector's din directly, for stimulus generation and for link-level self-test.

Parameters:
- PAT_W, 4, pattern length in bits (2..16).
- CNT_W, 8, width of the repeat-count input.
- GAP_W, 4, width of the inter-repetition gap-length input.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a burst; sampled only in IDLE.
- abort  input  1  synchronous; cancels the burst in progress.
- pattern  input  PAT_W  pattern to send, MSB transmitted first; latched on accepted start.
- repeat_cnt  input  CNT_W  number of pattern repetitions; latched on accepted start.
- gap_len  input  GAP_W  idle cycles between repetitions; latched on accepted start.
- dout  output  1  serial data bit; registered.
- dout_valid  output  1  high while dout carries a pattern (or parity) bit; registered.
- frame_start  output  1  high together with the first bit of each repetition.
- busy  output  1  high whenever present_state != IDLE.
- done  output  1  single-cycle pulse at normal burst completion.
- present_state  output  3  current FSM state, for debug and verification.

Behaviour:
- States and encodings: IDLE=000, SHIFT=001, GAP=010, DONE=011. Other encodings go to IDLE.
- Reset (asynchronous): state=IDLE; dout, dout_valid, frame_start, done = 0; shift register, bit counter, repeat counter and gap counter cleared.
- Reset mid-burst: all outputs drop in the same cycle. No done pulse is issued.
- IDLE:
  - start=1 and abort=0 at edge k: latch pattern, repeat_cnt and gap_len.
  - If repeat_cnt != 0, go to SHIFT. First bit, pattern[PAT_W-1], appears in cycle k+1 with dout_valid=1 and frame_start=1.
  - If repeat_cnt == 0, go to DONE. No bits are sent.
- SHIFT:
  - One bit per cycle, MSB first. dout_valid=1 throughout.
  - After the last bit of a repetition, decrement the remaining count.
  - Remaining count 0: go to DONE.
  - Remaining count > 0 and gap_len > 0: go to GAP.
  - Remaining count > 0 and gap_len == 0: start the next repetition in the next cycle with no idle cycle between them, frame_start=1 again.
- GAP: exactly gap_len cycles with dout=0 and dout_valid=0, then SHIFT. No gap is inserted after the final repetition.
- DONE: one cycle with done=1, dout_valid=0, then IDLE. A new start is accepted in the first IDLE cycle after DONE.
- Outside SHIFT: dout=0 whenever dout_valid=0.
- start while busy: ignored. Inputs are not re-latched.
- Changes to pattern, repeat_cnt or gap_len while busy have no effect.
- abort=1 in SHIFT, GAP or DONE: IDLE at the next edge, no done pulse, outputs 0 in the following cycle.
- abort and start together in IDLE: abort wins and nothing starts.
- Total burst length from start to done, for repeat_cnt = R > 0 and gap_len = G:
  - R*PAT_W + (R-1)*G cycles of SHIFT/GAP, then 1 DONE cycle.
  - With the optional feature compiled in, use PAT_W+1 in place of PAT_W.
- Counters saturate at 0 and never wrap. repeat_cnt at its maximum value (2^CNT_W - 1) is sent in full.

Optional Feature:
- Macro: SERIAL_PATTERN_TX_PARITY_EN.
- Defined: after the last pattern bit of each repetition, one extra bit is sent with dout_valid=1. Its value is the even-parity bit, the XOR of all PAT_W pattern bits. The gap and the DONE transition follow the parity bit.
- Undefined: no parity bit; each frame is exactly PAT_W bits.

Test Plan:
- pattern=4'b1101, repeat=1, gap=0, start at cycle 0 -> dout 1,1,0,1 in cycles 1-4 with dout_valid=1; frame_start only in cycle 1; done=1 in cycle 5; IDLE in cycle 6. Looped into a 1101 Moore detector, the detector output goes high once.
- pattern=4'b1101, repeat=3, gap=2 -> 1101,00,1101,00,1101 on dout. dout_valid low exactly during the gap cycles; frame_start in cycles 1, 7 and 13; done in cycle 17.
- repeat=0 -> dout_valid never asserts; done in cycle 1; busy high for cycle 1 only.
- repeat=2, gap=3, abort asserted during the 3rd bit of the 2nd repetition -> IDLE next cycle; outputs 0; no done pulse. A start pulsed mid-burst is ignored with no re-latch.
- reset asserted asynchronously mid-GAP -> present_state=000 and all outputs 0 immediately. A following start runs a clean burst.
- With SERIAL_PATTERN_TX_PARITY_EN, pattern=4'b1101, repeat=1 -> dout 1,1,0,1,1 in cycles 1-5; done in cycle 6.
